// File: rtl/alu_run_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_run_accum                                              |
// | Description : Running-sum stage behind the ALU. It adds a programmed     |
// |               number of results with a sticky carry flag and hands the   |
// |               sum downstream through a valid/ready handshake.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module alu_run_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] runsum,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_runsum;
  logic             r_overflow;

  logic             w_start_ok;
  logic             w_accept;
  logic             w_last;
  logic [CNT_W-1:0] w_count_inc;
  logic [WIDTH:0]   w_sum_ext;

  assign w_start_ok  = (r_state == ST_IDLE) && start && (len != '0);
  // abort wins over a beat offered in the same cycle
  assign w_accept    = (r_state == ST_ACCUM) && in_valid && !abort;
  assign w_count_inc = r_count + c_one;
  assign w_last      = (w_count_inc == r_len);
  assign w_sum_ext   = {1'b0, r_runsum} + {1'b0, in_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (abort)                  w_state_nxt = ST_IDLE;
        else if (w_accept && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (abort || out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len      <= '0;
      r_count    <= '0;
      r_runsum   <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_len      <= len;
      r_count    <= '0;
      r_runsum   <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_count    <= w_count_inc;
      r_runsum   <= w_sum_ext[WIDTH-1:0];
      r_overflow <= r_overflow | w_sum_ext[WIDTH];
    end
  end

  // handshake outputs come straight from the state register
  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign runsum    = r_runsum;
  assign out_sum   = r_runsum;
  assign out_count = r_count;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/alu_run_accum.md
# alu_run_accum

Running-sum stage placed directly downstream of the 16-bit ALU. It consumes one ALU result per accepted beat, accumulates a programmed number of results modulo 2^WIDTH, and flags unsigned carry-out. It presents the final sum to the next stage through a valid/ready handshake. The live accumulator value is exported as `runsum` for waveform dumps and monitors.

## Interface
- `WIDTH`, 16, data width of ALU result and accumulator
- `CNT_W`, 10, width of sample count and length (max run 1023 samples)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `len`  in  CNT_W  number of samples in the run; captured with `start`
- `abort`  in  1  synchronous abandon of the current run
- `in_valid`  in  1  ALU result present on `in_data`
- `in_data`  in  WIDTH  ALU `sum` output
- `in_ready`  out  1  stage accepts a beat this cycle
- `runsum`  out  WIDTH  live accumulator value
- `out_valid`  out  1  final result available
- `out_sum`  out  WIDTH  final accumulated sum
- `out_count`  out  CNT_W  samples accumulated (equals captured `len`)
- `overflow`  out  1  sticky: at least one unsigned carry-out in this run
- `out_ready`  in  1  downstream accepts the result
- `busy`  out  1  state is not IDLE

## Operation
- States: IDLE, ACCUM, DONE. Encoding is free. No other reachable state exists.
- IDLE:
  - `start`=1 and `len`!=0: capture `len`, clear `runsum`, count, and `overflow`, then go to ACCUM.
  - `start` with `len`=0: ignored, stay in IDLE.
- ACCUM:
  - `in_ready`=1.
  - Beat accepted when `in_valid`&&`in_ready`: `runsum` <= (`runsum`+`in_data`) mod 2^WIDTH, count <= count+1.
  - Carry out of bit WIDTH-1 sets `overflow`. It stays set until the next accepted `start` or reset.
  - The beat that makes count equal the captured `len` moves the state to DONE.
- DONE:
  - `out_valid`=1, and `out_sum`=`runsum`, `out_count`=count, both held stable.
  - Stays until `out_ready`=1, then goes to IDLE.
  - `runsum` keeps the final value in IDLE until the next `start`.
- `in_ready`=0 in IDLE and DONE. Beats offered there are not consumed.
- `start` in ACCUM or DONE is ignored.
- `abort`=1 in ACCUM or DONE: go to IDLE next cycle. `out_valid` drops, and no beat is accepted that cycle. `runsum` and `overflow` keep their values.
- `abort` has priority over beat acceptance and over `out_ready`.
- All arithmetic is unsigned. `in_data` is not sign-extended.

## Timing
- Reset values: state IDLE; `runsum`, `out_sum`, `out_count`, count, and `overflow` are 0; `in_ready`, `out_valid`, and `busy` are 0.
- Reset mid-run discards everything immediately, with no handshake completion.
- `in_ready`, `out_valid`, and `busy` are decoded from registered state only, with no combinational path from inputs.
- `start` at edge N puts the block in ACCUM, with `in_ready`=1, in cycle N+1.
- `runsum` reflects a beat accepted at edge N in the following cycle.
- Last beat at edge N gives `out_valid`=1 in cycle N+1. Minimum run: `len`=1 gives `out_valid` 2 cycles after `start`.
- `out_valid`&&`out_ready` at edge M gives IDLE in M+1. A new `start` is accepted at edge M+1 at the earliest.
- Throughput: one beat per cycle in ACCUM. Gaps in `in_valid` only stall; they do not change the result.
- Count reaching 2^CNT_W-1 (`len`=1023) terminates normally, with no wrap.

## Test plan
- Basic run: `start`, `len`=3, beats 5,7,9 back-to-back -> `out_valid` one cycle after the third beat, `out_sum`=21, `out_count`=3, `overflow`=0.
- Wrap: `len`=2, beats 0xFFFF,0x0003 -> `out_sum`=0x0002, `overflow`=1. The next run `len`=1 with beat 4 -> `out_sum`=4, `overflow`=0.
- Backpressure and gaps: `len`=4 with `in_valid` toggled 1,0,1,0…, beats 1,2,3,4, and `out_ready` held 0 for 5 cycles:
  - `out_sum`=10 stays stable while waiting.
  - `in_ready`=0 in DONE.
  - IDLE one cycle after `out_ready`=1.
- Ignored controls:
  - `start` with `len`=0 -> stays IDLE, `busy`=0.
  - `start` pulsed mid-run (`len`=2, beats 6,6) -> `out_sum`=12, captured `len` unchanged.
- Abort and reset:
  - `abort` after 2 of `len`=5 beats (3,3) -> IDLE next cycle, `out_valid` never set, `runsum`=6.
  - `reset` asserted mid-run -> all outputs 0 asynchronously.
- Soak: 1000 runs with random `len` 1..8 and random data 0..9 against a modulo-2^16 reference model -> every `out_sum`, `out_count`, and `overflow` matches.
